// File: rtl/layer_seq_fix_pkg.sv
// rtl/layer_seq_fix_pkg.sv - state encoding and address-width helper shared by the layer sequencer
package layer_seq_fix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    // Width of an index over n entries; a single-entry space still gets one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_fix_idx_cnt.sv
// rtl/layer_seq_fix_idx_cnt.sv - modulo-MOD up-counter with load-zero, increment enable and terminal flag
module layer_seq_fix_idx_cnt
    import layer_seq_fix_pkg::*;
#(
    parameter int MOD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    output logic [addr_w(MOD)-1:0] cnt,
    output logic                   last
);
    localparam int CW = addr_w(MOD);

    assign last = (cnt == CW'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/layer_seq_fix.sv
// rtl/layer_seq_fix.sv - fully-connected layer sequencer; fetches operands, drives the MAC, hands results downstream
module layer_seq_fix
    import layer_seq_fix_pkg::*;
#(
    parameter int W    = 16,
    parameter int N    = 784,
    parameter int M    = 10,
    parameter int RELU = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [addr_w(N)-1:0]   in_addr,
    input  logic [W-1:0]           in_rdata,
    output logic [addr_w(N*M)-1:0] w_addr,
    input  logic [W-1:0]           w_rdata,
    output logic [W-1:0]           mac_x,
    output logic [W-1:0]           mac_c,
    output logic                   mac_en,
    output logic                   mac_clr,
    input  logic [W-1:0]           mac_o,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W-1:0]           res_data,
    output logic [addr_w(M)-1:0]   res_idx
);
    localparam int IW = addr_w(N);
    localparam int WW = addr_w(N*M);
    localparam int JW = addr_w(M);

    state_t        state;
    logic [IW-1:0] i_val;
    logic          i_last;
    logic [JW-1:0] j_val;
    logic          j_last;
    logic          accept_start;
    logic          xfer;
    logic          issue;

    assign mac_x = in_rdata;
    assign mac_c = w_rdata;

    assign accept_start = (state == ST_IDLE) && start;
    assign xfer         = (state == ST_OUT) && res_ready;

    // Address 0 goes out on CLR entry; CLR and each RUN cycle k then prefetch k+1 while it exists.
    assign issue = ((state == ST_CLR) && (N > 1)) ||
                   ((state == ST_RUN) && ((int'(i_val) + 2) < N));

    layer_seq_fix_idx_cnt #(.MOD(N)) u_i_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_CLR),
        .inc  (state == ST_RUN),
        .cnt  (i_val),
        .last (i_last)
    );

    layer_seq_fix_idx_cnt #(.MOD(M)) u_j_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_start),
        .inc  (xfer && !j_last),
        .cnt  (j_val),
        .last (j_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            in_addr   <= '0;
            w_addr    <= '0;
        end else begin
            done    <= 1'b0;
            mac_clr <= 1'b0;
            if (issue) begin
                in_addr <= in_addr + IW'(1);
                w_addr  <= w_addr + WW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLR;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        in_addr <= '0;
                        w_addr  <= '0;
                    end
                end
                ST_CLR: begin
                    state  <= ST_RUN;
                    mac_en <= 1'b1;
                end
                ST_RUN: begin
                    if (i_last) begin
                        state  <= ST_DRAIN;
                        mac_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_OUT;
                    res_valid <= 1'b1;
                    res_data  <= ((RELU != 0) && mac_o[W-1]) ? '0 : mac_o;
                    res_idx   <= j_val;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (j_last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Next row's weights continue linearly from where this row stopped.
                            state   <= ST_CLR;
                            mac_clr <= 1'b1;
                            in_addr <= '0;
                            w_addr  <= w_addr + WW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq_fix.sv
// tb/tb_layer_seq_fix.sv - self-checking bench for layer_seq_fix with RAM and integer-multiply MAC stubs
module tb_layer_seq_fix;
    localparam int W = 16;
    localparam int N = 4;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_c = 1'b0;
    logic res_ready = 1'b0;
    int   cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [W-1:0] in_mem [N];
    logic [W-1:0] w_mem [N*M];

    // Instance 0 runs RELU=0, instance 1 RELU=1, on identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         busy, done, mac_en, mac_clr, res_valid;
        logic [1:0]   in_addr;
        logic [2:0]   w_addr;
        logic [0:0]   res_idx;
        logic [W-1:0] in_rdata, w_rdata, mac_x, mac_c, res_data;
        logic [W-1:0] mac_o = '0;
        int           en_n = 0, clr_n = 0, both_n = 0, done_n = 0;
        int           got_idx[$];
        logic [W-1:0] got_data[$];
        int           ia_q[$], wa_q[$];

        layer_seq_fix #(.W(W), .N(N), .M(M), .RELU(g)) dut (
            .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
            .in_addr(in_addr), .in_rdata(in_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
            .mac_x(mac_x), .mac_c(mac_c), .mac_en(mac_en), .mac_clr(mac_clr), .mac_o(mac_o),
            .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
        );

        always @(posedge clk) begin
            in_rdata <= in_mem[in_addr];
            w_rdata  <= w_mem[w_addr];
            if (mac_clr) mac_o <= '0;
            else if (mac_en) mac_o <= mac_o + mac_x * mac_c;
        end

        always @(negedge clk) begin
            if (mac_en) en_n++;
            if (mac_clr) clr_n++;
            if (mac_en && mac_clr) both_n++;
            if (done) done_n++;
            if (res_valid && res_ready) begin
                got_idx.push_back(int'(res_idx));
                got_data.push_back(res_data);
            end
            if (mac_en || mac_clr) begin
                ia_q.push_back(int'(in_addr));
                wa_q.push_back(int'(w_addr));
            end
        end
    end

    // Single-neuron, single-input instance.
    logic         c_busy, c_done, c_mac_en, c_mac_clr, c_res_valid;
    logic [0:0]   c_in_addr, c_w_addr, c_res_idx;
    logic [W-1:0] c_in_rdata, c_w_rdata, c_mac_x, c_mac_c, c_res_data;
    logic [W-1:0] c_mac_o = '0;
    logic [W-1:0] c_in_word, c_w_word;
    int           c_en = 0, c_clr = 0, c_done_n = 0, c_addr_nz = 0, c_out_cyc = -1, c_done_cyc = -1;
    logic         c_prev_valid = 1'b0;
    int           c_idx[$];
    logic [W-1:0] c_got[$];

    layer_seq_fix #(.W(W), .N(1), .M(1), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(c_busy), .done(c_done),
        .in_addr(c_in_addr), .in_rdata(c_in_rdata), .w_addr(c_w_addr), .w_rdata(c_w_rdata),
        .mac_x(c_mac_x), .mac_c(c_mac_c), .mac_en(c_mac_en), .mac_clr(c_mac_clr), .mac_o(c_mac_o),
        .res_valid(c_res_valid), .res_ready(res_ready), .res_data(c_res_data), .res_idx(c_res_idx)
    );

    always @(posedge clk) begin
        c_in_rdata <= (c_in_addr == 1'b0) ? c_in_word : '0;
        c_w_rdata  <= (c_w_addr == 1'b0) ? c_w_word : '0;
        if (c_mac_clr) c_mac_o <= '0;
        else if (c_mac_en) c_mac_o <= c_mac_o + c_mac_x * c_mac_c;
    end

    always @(negedge clk) begin
        if (c_mac_en) c_en++;
        if (c_mac_clr) c_clr++;
        if (c_done) begin
            c_done_n++;
            c_done_cyc = cyc_n;
        end
        if (c_res_valid && !c_prev_valid) c_out_cyc = cyc_n;
        c_prev_valid = c_res_valid;
        if (c_res_valid && res_ready) begin
            c_idx.push_back(int'(c_res_idx));
            c_got.push_back(c_res_data);
        end
        if ((c_mac_en || c_mac_clr) && (c_in_addr != 1'b0 || c_w_addr != 1'b0)) c_addr_nz++;
    end

    int n_pass = 0;
    int n_chk = 0;
    int s_en, s_clr, s_both, s_done, s_res0, s_res1, s_tr;

    typedef struct {
        logic [N-1:0][W-1:0]   in_v;
        logic [N*M-1:0][W-1:0] w_v;
        logic [M-1:0][W-1:0]   exp_a;
        logic [M-1:0][W-1:0]   exp_b;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic longint outs(input int g);
        if (g == 0)
            return longint'({g_dut[0].busy, g_dut[0].done, g_dut[0].mac_en, g_dut[0].mac_clr,
                             g_dut[0].res_valid, g_dut[0].res_data, g_dut[0].res_idx,
                             g_dut[0].in_addr, g_dut[0].w_addr});
        else if (g == 1)
            return longint'({g_dut[1].busy, g_dut[1].done, g_dut[1].mac_en, g_dut[1].mac_clr,
                             g_dut[1].res_valid, g_dut[1].res_data, g_dut[1].res_idx,
                             g_dut[1].in_addr, g_dut[1].w_addr});
        else
            return longint'({c_busy, c_done, c_mac_en, c_mac_clr, c_res_valid, c_res_data,
                             c_res_idx, c_in_addr, c_w_addr});
    endfunction

    // Reference: dot product of row j with the inputs, wrapped to W bits, then optional ReLU.
    function automatic int model(input int j, input int relu);
        int sum;
        logic signed [W-1:0] t;
        sum = 0;
        for (int i = 0; i < N; i++)
            sum += int'($signed(in_mem[i])) * int'($signed(w_mem[j*N+i]));
        t = sum[W-1:0];
        if (relu != 0 && t < 0) return 0;
        return int'(t);
    endfunction

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return W'($urandom);
        return W'($urandom_range(0, 40)) - W'(20);
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N; i++) in_mem[i] = v.in_v[i];
        for (int i = 0; i < N*M; i++) w_mem[i] = v.w_v[i];
    endtask

    task automatic snap();
        s_en   = g_dut[0].en_n;
        s_clr  = g_dut[0].clr_n;
        s_both = g_dut[0].both_n + g_dut[1].both_n;
        s_done = g_dut[0].done_n;
        s_res0 = g_dut[0].got_data.size();
        s_res1 = g_dut[1].got_data.size();
        s_tr   = g_dut[0].ia_q.size();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int ready_pct, input bit stray);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (g_dut[0].done_n > s_done) break;
            @(posedge clk); #1;
            res_ready = ($urandom_range(0, 99) < ready_pct);
            start = stray && (cyc == 3);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic verify(input string tag, input logic [M-1:0][W-1:0] ea, input logic [M-1:0][W-1:0] eb);
        int bad;
        check($sformatf("%s done pulses", tag), g_dut[0].done_n - s_done, 1);
        check($sformatf("%s result count a", tag), g_dut[0].got_data.size() - s_res0, M);
        check($sformatf("%s result count b", tag), g_dut[1].got_data.size() - s_res1, M);
        for (int j = 0; j < M; j++) begin
            if (s_res0 + j < g_dut[0].got_data.size()) begin
                check($sformatf("%s a[%0d] idx", tag, j), g_dut[0].got_idx[s_res0+j], j);
                check($sformatf("%s a[%0d] data", tag, j), $signed(g_dut[0].got_data[s_res0+j]), $signed(ea[j]));
            end
            if (s_res1 + j < g_dut[1].got_data.size()) begin
                check($sformatf("%s b[%0d] idx", tag, j), g_dut[1].got_idx[s_res1+j], j);
                check($sformatf("%s b[%0d] data", tag, j), $signed(g_dut[1].got_data[s_res1+j]), $signed(eb[j]));
            end
        end
        check($sformatf("%s mac_en cycles", tag), g_dut[0].en_n - s_en, N*M);
        check($sformatf("%s mac_clr cycles", tag), g_dut[0].clr_n - s_clr, M);
        check($sformatf("%s en/clr overlap", tag), g_dut[0].both_n + g_dut[1].both_n - s_both, 0);
        check($sformatf("%s addr trace len", tag), g_dut[0].ia_q.size() - s_tr, M*(N+1));
        bad = 0;
        for (int j = 0; j < M; j++) begin
            for (int k = -1; k < N; k++) begin
                int p, ia;
                p  = s_tr + j*(N+1) + k + 1;
                ia = (k + 1 < N) ? k + 1 : N - 1;
                if (p < g_dut[0].ia_q.size())
                    if (g_dut[0].ia_q[p] != ia || g_dut[0].wa_q[p] != j*N + ia) bad++;
            end
        end
        check($sformatf("%s addr trace", tag), bad, 0);
    endtask

    initial begin
        int bad, e0;
        logic [M-1:0][W-1:0] ea, eb;

        tbl[0].in_v  = {16'd4, 16'd3, 16'd2, 16'd1};
        tbl[0].w_v   = {-16'sd1, 16'd0, 16'd0, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
        tbl[0].exp_a = {-16'sd2, 16'd10};
        tbl[0].exp_b = {16'd0, 16'd10};
        tbl[1].in_v  = {16'd5, 16'd5, 16'd5, 16'd5};
        tbl[1].w_v   = {16'd0, 16'd0, 16'd0, 16'd3, -16'sd1, -16'sd1, -16'sd1, -16'sd1};
        tbl[1].exp_a = {16'd15, -16'sd20};
        tbl[1].exp_b = {16'd15, 16'd0};
        tbl[2].in_v  = {16'd4, -16'sd3, 16'd2, -16'sd1};
        tbl[2].w_v   = {16'd0, -16'sd1, 16'd0, -16'sd1, 16'd1, 16'd1, 16'd1, 16'd1};
        tbl[2].exp_a = {16'd4, 16'd2};
        tbl[2].exp_b = {16'd4, 16'd2};
        tbl[3].in_v  = {16'd0, 16'd0, 16'd0, 16'd16384};
        tbl[3].w_v   = {16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd4};
        tbl[3].exp_a = {16'hC000, 16'd0};
        tbl[3].exp_b = {16'd0, 16'd0};

        load_vec(tbl[0]);
        c_in_word = -16'sd3;
        c_w_word  = 16'd5;

        repeat (3) @(negedge clk);
        check("reset outputs a", outs(0), 0);
        check("reset outputs b", outs(1), 0);
        check("reset outputs c", outs(2), 0);
        rst = 1'b0;
        res_ready = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_vec(tbl[v]);
            snap();
            pulse_start();
            wait_done(100, 1'b0);
            verify($sformatf("tbl%0d", v), tbl[v].exp_a, tbl[v].exp_b);
        end

        // Back-pressure on neuron 0's result.
        load_vec(tbl[0]);
        res_ready = 1'b0;
        snap();
        pulse_start();
        for (int t = 0; t < 50 && !g_dut[0].res_valid; t++) @(negedge clk);
        check("bp reached OUT", g_dut[0].res_valid, 1);
        e0 = g_dut[0].en_n;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            if (!(g_dut[0].res_valid && g_dut[0].res_data == 16'd10 && g_dut[0].res_idx == 1'b0 &&
                  !g_dut[0].mac_en && !g_dut[0].mac_clr)) bad++;
            @(negedge clk);
        end
        check("bp held stable", bad, 0);
        check("bp no mac_en while held", g_dut[0].en_n - e0, 0);
        res_ready = 1'b1;
        @(negedge clk);
        check("bp clr right after accept", g_dut[0].mac_clr, 1);
        check("bp valid dropped after accept", g_dut[0].res_valid, 0);
        wait_done(100, 1'b0);
        verify("bp", tbl[0].exp_a, tbl[0].exp_b);

        // Abort in RUN k=2, then a clean restart with a stray start while busy.
        load_vec(tbl[1]);
        snap();
        pulse_start();
        for (int t = 0; t < 40 && (g_dut[0].en_n - s_en) < 3; t++) @(negedge clk);
        check("abort reached RUN k=2", g_dut[0].en_n - s_en, 3);
        rst = 1'b1;
        @(negedge clk);
        check("abort outputs a", outs(0), 0);
        check("abort outputs b", outs(1), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort no done", g_dut[0].done_n - s_done, 0);
        load_vec(tbl[0]);
        snap();
        pulse_start();
        wait_done(100, 1'b1);
        verify("restart", tbl[0].exp_a, tbl[0].exp_b);

        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < N; i++) in_mem[i] = rnd_word();
            for (int i = 0; i < N*M; i++) w_mem[i] = rnd_word();
            for (int j = 0; j < M; j++) begin
                ea[j] = W'(model(j, 0));
                eb[j] = W'(model(j, 1));
            end
            snap();
            pulse_start();
            wait_done($urandom_range(40, 100), 1'($urandom_range(0, 1)));
            verify($sformatf("rnd%0d", p), ea, eb);
        end

        // N=1, M=1 instance.
        res_ready = 1'b1;
        @(posedge clk); #1 start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        for (int t = 0; t < 30 && c_done_n == 0; t++) @(negedge clk);
        @(negedge clk);
        check("n1 done pulses", c_done_n, 1);
        check("n1 result count", c_got.size(), 1);
        if (c_got.size() > 0) begin
            check("n1 data", $signed(c_got[0]), -15);
            check("n1 idx", c_idx[0], 0);
        end
        check("n1 mac_en cycles", c_en, 1);
        check("n1 mac_clr cycles", c_clr, 1);
        check("n1 addresses stay 0", c_addr_nz, 0);
        check("n1 done after OUT", c_done_cyc - c_out_cyc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
